// File: rtl/oam_dma_ctrl.sv
// oam_dma_ctrl - sprite DMA controller and memory-bus arbiter.
//
// A CPU write to DMA_REG halts the CPU and copies the 256 bytes of page
// {cpu_d_out, 8'h00} to the PPU OAM data port (OAM_PORT), one READ/WRITE
// pair per byte. While idle, CPU bus cycles pass straight through to memory.
//
// Optional feature macro: OAM_DMA_ALIGN_EN
//   defined   - a HALT cycle with cyc_odd=1 is followed by one ALIGN dummy
//               cycle (stall 513 or 514 cycles).
//   undefined - HALT always proceeds to READ (stall always 513 cycles).
//
// Ports:
//   clk_i        system clock, rising edge
//   rst_i        synchronous active-low reset
//   cpu_addr_i   CPU bus address
//   cpu_d_out_i  CPU write data
//   cpu_we_i     CPU write strobe
//   cpu_rdy_o    high lets the CPU advance, low halts it
//   mem_addr_o   memory address
//   mem_d_out_o  memory write data
//   mem_we_o     memory write strobe
//   mem_d_in_i   memory read data (combinational, same cycle as mem_addr_o)
//   busy_o       high while the DMA owns the bus
module oam_dma_ctrl #(
  parameter logic [15:0] DMA_REG  = 16'h4014,
  parameter logic [15:0] OAM_PORT = 16'h2004
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [15:0] cpu_addr_i,
  input  logic [7:0]  cpu_d_out_i,
  input  logic        cpu_we_i,
  output logic        cpu_rdy_o,
  output logic [15:0] mem_addr_o,
  output logic [7:0]  mem_d_out_o,
  output logic        mem_we_o,
  input  logic [7:0]  mem_d_in_i,
  output logic        busy_o
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HALT,
    S_ALIGN,
    S_READ,
    S_WRITE
  } state_t;

  state_t      state_q;
  logic        busy_q;
  logic [7:0]  page_q;
  logic [7:0]  idx_q;
  logic [7:0]  data_q;

`ifdef OAM_DMA_ALIGN_EN
  // Free-running cycle parity, used only to decide whether ALIGN is needed.
  logic cyc_odd_q;

  always_ff @(posedge clk_i) begin
    if (!rst_i) cyc_odd_q <= 1'b0;
    else        cyc_odd_q <= ~cyc_odd_q;
  end
`endif

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q <= S_IDLE;
      busy_q  <= 1'b0;
      page_q  <= 8'h00;
      idx_q   <= 8'h00;
      data_q  <= 8'h00;
    end else begin
      case (state_q)
        S_IDLE: begin
          // The trigger write itself still reaches memory via the pass-through.
          if (cpu_we_i && (cpu_addr_i == DMA_REG)) begin
            page_q  <= cpu_d_out_i;
            idx_q   <= 8'h00;
            busy_q  <= 1'b1;
            state_q <= S_HALT;
          end
        end
        S_HALT: begin
`ifdef OAM_DMA_ALIGN_EN
          state_q <= cyc_odd_q ? S_ALIGN : S_READ;
`else
          state_q <= S_READ;
`endif
        end
        S_ALIGN: state_q <= S_READ;
        S_READ: begin
          data_q  <= mem_d_in_i;
          state_q <= S_WRITE;
        end
        S_WRITE: begin
          // idx wraps within the page, so the source never leaves it.
          idx_q <= idx_q + 8'd1;
          if (idx_q == 8'hFF) begin
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end else begin
            state_q <= S_READ;
          end
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign busy_o    = busy_q;
  assign cpu_rdy_o = ~busy_q;

  // Bus mux. Reset forces the pass-through immediately so an aborted
  // transfer cannot issue another OAM write in the reset cycle.
  always_comb begin
    mem_addr_o  = cpu_addr_i;
    mem_d_out_o = cpu_d_out_i;
    mem_we_o    = cpu_we_i;
    if (rst_i && busy_q) begin
      case (state_q)
        S_HALT: begin
          mem_addr_o = cpu_addr_i;
          mem_we_o   = 1'b0;
        end
        S_ALIGN, S_READ: begin
          mem_addr_o = {page_q, idx_q};
          mem_we_o   = 1'b0;
        end
        S_WRITE: begin
          mem_addr_o  = OAM_PORT;
          mem_d_out_o = data_q;
          mem_we_o    = 1'b1;
        end
        default: begin
          mem_we_o = 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_oam_dma_ctrl.sv
// Directed bench for oam_dma_ctrl with a combinational memory model.
module tb_oam_dma_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_d;
  logic        cpu_we;
  logic        cpu_rdy;
  logic [15:0] mem_addr;
  logic [7:0]  mem_dout;
  logic        mem_we;
  logic [7:0]  mem_din;
  logic        busy;

  logic [7:0]  mem [0:65535];

  oam_dma_ctrl dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .cpu_addr_i  (cpu_addr),
    .cpu_d_out_i (cpu_d),
    .cpu_we_i    (cpu_we),
    .cpu_rdy_o   (cpu_rdy),
    .mem_addr_o  (mem_addr),
    .mem_d_out_o (mem_dout),
    .mem_we_o    (mem_we),
    .mem_d_in_i  (mem_din),
    .busy_o      (busy)
  );

  always #5 clk = ~clk;

  assign mem_din = mem[mem_addr];

  always @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= mem_dout;
  end

  // Reference cycle parity: 0 after reset, toggles every clock.
  logic tb_par;
  always @(posedge clk) begin
    if (!rst) tb_par <= 1'b0;
    else      tb_par <= ~tb_par;
  end

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Results of the last transfer.
  int          stall;
  logic [7:0]  wq[$];
  int          bad_bus;
  int          zero_hit;
  int          par_mixed;
  logic [15:0] last_rd;

  function automatic int data_errs(input logic [7:0] key);
    int e;
    e = 0;
    for (int i = 0; i < wq.size(); i++)
      if (wq[i] !== (8'(i) ^ key)) e++;
    return e;
  endfunction

  task automatic run_dma(input logic [7:0] pg, input logic odd_halt,
                         input int retrig_at, input int abort_at);
    logic [15:0] prev_addr;
    logic        prev_par;
    logic        first_par;
    bit          have_par;
    int          cyc;
    wq.delete();
    stall = 0; bad_bus = 0; zero_hit = 0; par_mixed = 0;
    have_par = 0; prev_addr = 16'h0; prev_par = 1'b0; first_par = 1'b0;
    last_rd = 16'h0;
    @(negedge clk);
    // After the trigger edge tb_par flips, so trigger when it differs now.
    while (tb_par == odd_halt) @(negedge clk);
    cpu_addr = 16'h4014; cpu_d = pg; cpu_we = 1'b1;
    @(negedge clk);
    cpu_we = 1'b0; cpu_d = 8'h00;
    chk("rdy_fall",  {31'd0, cpu_rdy}, 0);
    chk("halt_par",  {31'd0, tb_par}, {31'd0, odd_halt});
    chk("halt_we",   {31'd0, mem_we}, 0);
    chk("halt_addr", {16'd0, mem_addr}, 32'h4014);
    cyc = 0;
    while (!cpu_rdy && cyc < 600) begin
      stall++;
      if (busy !== 1'b1) bad_bus++;
      if (cyc == 1) chk("c1_we", {31'd0, mem_we}, 0);
      if (mem_addr == 16'h0000) zero_hit++;
      if (mem_we) begin
        if (mem_addr != 16'h2004) bad_bus++;
        if (!have_par) begin
          first_par = prev_par; have_par = 1;
        end else if (prev_par !== first_par) begin
          par_mixed++;
        end
        last_rd = prev_addr;
        if (wq.size() == retrig_at) begin
          cpu_addr = 16'h4014; cpu_d = 8'h03; cpu_we = 1'b1;
        end
        if (wq.size() == abort_at) rst = 1'b0;
        wq.push_back(mem_dout);
      end else begin
        cpu_we = 1'b0;
      end
      prev_addr = mem_addr;
      prev_par  = tb_par;
      @(negedge clk);
      cyc++;
    end
    if (cyc >= 600) chk("dma_timeout", 1, 0);
    if (abort_at >= 0) begin
      chk("abort_busy", {31'd0, busy}, 0);
      chk("abort_rdy",  {31'd0, cpu_rdy}, 1);
    end
    rst = 1'b1;
    cpu_we = 1'b0;
  endtask

  initial begin
    int wr_cnt;
    logic [15:0] nt_addr [2];
    rst = 1'b0; cpu_addr = 16'h1234; cpu_d = 8'h77; cpu_we = 1'b1;
    for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
    for (int i = 0; i < 256; i++) begin
      mem[16'h0200 + i] = 8'(i) ^ 8'hA5;
      mem[16'h0300 + i] = 8'(i) ^ 8'h11;
      mem[16'hFF00 + i] = 8'(i) ^ 8'h3C;
    end

    // Reset state and pass-through during reset.
    repeat (2) @(negedge clk);
    chk("rst_rdy",  {31'd0, cpu_rdy}, 1);
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_addr", {16'd0, mem_addr}, 32'h1234);
    chk("rst_we",   {31'd0, mem_we}, 1);
    cpu_we = 1'b0; rst = 1'b1;

    // Idle CPU read.
    @(negedge clk);
    chk("idle_addr", {16'd0, mem_addr}, 32'h1234);
    chk("idle_we",   {31'd0, mem_we}, 0);

    // Writes near, but not at, the trigger register.
    nt_addr[0] = 16'h4015; nt_addr[1] = 16'h4013;
    for (int k = 0; k < 2; k++) begin
      cpu_addr = nt_addr[k]; cpu_d = 8'h02; cpu_we = 1'b1;
      @(negedge clk);
      chk("nt_we", {31'd0, mem_we}, 1);
      cpu_we = 1'b0;
      @(negedge clk);
      chk("nt_rdy",  {31'd0, cpu_rdy}, 1);
      chk("nt_busy", {31'd0, busy}, 0);
    end

    // Page $02, even parity at HALT.
    run_dma(8'h02, 1'b0, -1, -1);
    chk("a_stall", stall, 513);
    chk("a_count", wq.size(), 256);
    chk("a_data",  data_errs(8'hA5), 0);
    chk("a_first", {24'd0, wq[0]}, 32'hA5);
    chk("a_last",  {24'd0, wq[255]}, 32'h5A);
    chk("a_bus",   bad_bus, 0);
    chk("a_lastrd", {16'd0, last_rd}, 32'h02FF);
    chk("a_trigmem", {24'd0, mem[16'h4014]}, 32'h02);
    chk("a_rdpar", par_mixed, 0);

    // Page $02, odd parity at HALT.
    run_dma(8'h02, 1'b1, -1, -1);
`ifdef OAM_DMA_ALIGN_EN
    chk("b_stall", stall, 514);
`else
    chk("b_stall", stall, 513);
`endif
    chk("b_count", wq.size(), 256);
    chk("b_data",  data_errs(8'hA5), 0);
    chk("b_rdpar", par_mixed, 0);

    // Page $FF stays inside its page.
    run_dma(8'hFF, 1'b0, -1, -1);
    chk("c_stall",  stall, 513);
    chk("c_data",   data_errs(8'h3C), 0);
    chk("c_lastrd", {16'd0, last_rd}, 32'hFFFF);
    chk("c_zero",   zero_hit, 0);
    chk("c_idle",   {31'd0, busy}, 0);

    // Second trigger during WRITE of byte 10 is ignored.
    run_dma(8'h02, 1'b0, 10, -1);
    chk("d_stall", stall, 513);
    chk("d_count", wq.size(), 256);
    chk("d_data",  data_errs(8'hA5), 0);

    // Reset during byte 100 aborts the transfer.
    run_dma(8'h02, 1'b0, -1, 100);
    chk("e_stall", stall, 203);
    chk("e_count", wq.size(), 101);
    cpu_addr = 16'h1000;
    wr_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (mem_we && mem_addr == 16'h2004) wr_cnt++;
    end
    chk("e_nowr", wr_cnt, 0);
    chk("e_rdy",  {31'd0, cpu_rdy}, 1);
    cpu_addr = 16'h3000; cpu_d = 8'h5C; cpu_we = 1'b1;
    @(negedge clk);
    chk("e_pass_we",   {31'd0, mem_we}, 1);
    chk("e_pass_addr", {16'd0, mem_addr}, 32'h3000);
    cpu_we = 1'b0;
    @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
